speed_change_quiesce: RTL and testbench

// - Downstream responder to the speed controller's speed-change handshake (req_valid/req_ready/req_speed).
// - On a speed-change request: blocks new DRAM command issue and drains outstanding commands.
// - Then waits a guard interval, grants the request, and holds the block until the transition ends.
// - Guarantees no command is in flight while tCK/tRCD/tRP/tCL are switched.

---
 rtl/speed_change_quiesce.sv | 127 ++++++++++++
 tb/tb_speed_change_quiesce.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/speed_change_quiesce.sv
// Quiesces the DRAM command path around a speed change: block issue, drain, guard, grant,
// then hold the block until the speed controller's transition window closes.
module speed_change_quiesce #(
    parameter int OUTST_W        = 4,
    parameter int GUARD_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [2:0]         req_speed,
    output logic               req_ready,
    input  logic               speed_changing,
    input  logic               cmd_issue,
    input  logic               cmd_done,
    output logic               cmd_block,
    output logic [OUTST_W-1:0] outstanding,
    output logic [2:0]         grant_speed,
    output logic               busy,
    output logic               timeout_err,
    output logic               proto_err
);

    // Timer is shared by DRAIN, GUARD and XFER, so it must hold the larger terminal count.
    localparam int TMAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]      T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]      G_LAST  = TW'(GUARD_CYCLES - 1);
    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        GUARD,
        GRANT,
        XFER,
        ERR
    } state_t;

    state_t             state;
    logic [TW-1:0]      timer;
    logic [OUTST_W-1:0] cnt;
    logic               seen;

    assign req_ready   = (state == GRANT);
    assign cmd_block   = (state != IDLE);
    assign busy        = cmd_block;
    assign outstanding = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            cnt         <= '0;
            seen        <= 1'b0;
            grant_speed <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            // Issues are always counted, even illegal ones, so the drain stays truthful.
            if (cmd_issue && state != IDLE)
                proto_err <= 1'b1;
            if (cmd_issue && !cmd_done) begin
                if (cnt == CNT_MAX) proto_err <= 1'b1;
                else                cnt       <= cnt + 1'b1;
            end else if (cmd_done && !cmd_issue) begin
                if (cnt == '0) proto_err <= 1'b1;
                else           cnt       <= cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        grant_speed <= req_speed;
                        timer       <= '0;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!req_valid) begin
                        state <= IDLE;
                    end else if (cnt == '0 && !cmd_issue) begin
                        timer <= '0;
                        state <= GUARD;
                    end else if (timer == T_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ERR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GUARD: begin
                    if (!req_valid)           state <= IDLE;
                    else if (timer == G_LAST) state <= GRANT;
                    else                      timer <= timer + 1'b1;
                end
                GRANT: begin
                    if (req_valid) begin
                        timer <= '0;
                        seen  <= 1'b0;
                        state <= XFER;
                    end else begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    if (speed_changing)
                        seen <= 1'b1;
                    if (seen && !speed_changing) begin
                        state <= IDLE;
                    end else if (timer == T_LAST) begin
                        // Fail open: a stuck transition must not wedge the command path forever.
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ERR: begin
                    if (!req_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_speed_change_quiesce.sv
// Directed bench for speed_change_quiesce: grant latency, drain, transition release,
// drain timeout, counter corners, reset and abort paths.
module tb_speed_change_quiesce;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [2:0] req_speed;
    logic       speed_changing;
    logic       cmd_issue;
    logic       cmd_done;

    logic       req_ready, cmd_block, busy, timeout_err, proto_err;
    logic [3:0] outstanding;
    logic [2:0] grant_speed;

    logic       t_req_ready, t_cmd_block, t_busy, t_timeout_err, t_proto_err;
    logic [3:0] t_outstanding;
    logic [2:0] t_grant_speed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    speed_change_quiesce #(.OUTST_W(4), .GUARD_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_speed(req_speed),
        .req_ready(req_ready), .speed_changing(speed_changing), .cmd_issue(cmd_issue),
        .cmd_done(cmd_done), .cmd_block(cmd_block), .outstanding(outstanding),
        .grant_speed(grant_speed), .busy(busy), .timeout_err(timeout_err),
        .proto_err(proto_err)
    );

    speed_change_quiesce #(.OUTST_W(4), .GUARD_CYCLES(8), .TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_speed(req_speed),
        .req_ready(t_req_ready), .speed_changing(speed_changing), .cmd_issue(cmd_issue),
        .cmd_done(cmd_done), .cmd_block(t_cmd_block), .outstanding(t_outstanding),
        .grant_speed(t_grant_speed), .busy(t_busy), .timeout_err(t_timeout_err),
        .proto_err(t_proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_speed      = 3'd0;
        speed_changing = 1'b0;
        cmd_issue      = 1'b0;
        cmd_done       = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        step();
        chk("rst_block", 32'(cmd_block), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outst", 32'(outstanding), 0);
        chk("rst_speed", 32'(grant_speed), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        chk("rst_proto", 32'(proto_err), 0);

        // Idle grant: request at cycle 0, block at 1, one-cycle grant at 10.
        req_valid = 1'b1;
        req_speed = 3'd5;
        step();
        chk("idle_block_c1", 32'(cmd_block), 1);
        chk("idle_speed", 32'(grant_speed), 5);
        for (int c = 1; c <= 9; c++) begin
            chk("idle_noready", 32'(req_ready), 0);
            step();
        end
        chk("idle_ready_c10", 32'(req_ready), 1);
        step();
        chk("xfer_ready_off", 32'(req_ready), 0);
        chk("xfer_block", 32'(cmd_block), 1);

        // Transition window of 8 cycles; block must fall one cycle after it closes.
        req_valid      = 1'b0;
        speed_changing = 1'b1;
        repeat (8) step();
        speed_changing = 1'b0;
        chk("xfer_block_hold", 32'(cmd_block), 1);
        step();
        chk("xfer_block_fall", 32'(cmd_block), 0);
        chk("xfer_busy_fall", 32'(busy), 0);

        // Drain: 3 in flight, retired at cycles 5, 9, 20; grant expected at cycle 30.
        cmd_issue = 1'b1;
        repeat (3) step();
        cmd_issue = 1'b0;
        chk("drain_outst3", 32'(outstanding), 3);
        chk("drain_proto", 32'(proto_err), 0);
        for (int c = 0; c <= 29; c++) begin
            req_valid = 1'b1;
            req_speed = 3'd2;
            cmd_done  = (c == 5 || c == 9 || c == 20);
            step();
            if (c + 1 < 30) chk("drain_ready", 32'(req_ready), 0);
        end
        cmd_done = 1'b0;
        chk("drain_ready_c30", 32'(req_ready), 1);
        chk("drain_outst0", 32'(outstanding), 0);
        chk("drain_speed", 32'(grant_speed), 2);
        req_valid = 1'b0;
        step();
        chk("withdraw_block", 32'(cmd_block), 0);
        chk("withdraw_ready", 32'(req_ready), 0);

        // Drain timeout on the 16-cycle instance.
        do_reset();
        cmd_issue = 1'b1;
        step();
        cmd_issue = 1'b0;
        req_valid = 1'b1;
        step();
        for (int c = 1; c <= 16; c++) begin
            chk("tmo_pending", 32'(t_timeout_err), 0);
            step();
        end
        chk("tmo_set", 32'(t_timeout_err), 1);
        chk("tmo_block", 32'(t_cmd_block), 1);
        chk("tmo_ready", 32'(t_req_ready), 0);
        repeat (3) step();
        chk("err_hold_block", 32'(t_cmd_block), 1);
        chk("err_hold_ready", 32'(t_req_ready), 0);
        req_valid = 1'b0;
        step();
        chk("err_release", 32'(t_cmd_block), 0);
        chk("tmo_sticky", 32'(t_timeout_err), 1);

        // Counter corners.
        do_reset();
        cmd_issue = 1'b1;
        repeat (15) step();
        chk("cnt_15", 32'(outstanding), 15);
        chk("cnt_15_proto", 32'(proto_err), 0);
        step();
        chk("cnt_sat", 32'(outstanding), 15);
        chk("cnt_sat_proto", 32'(proto_err), 1);
        cmd_done = 1'b1;
        step();
        chk("cnt_both_max", 32'(outstanding), 15);
        do_reset();
        cmd_done = 1'b1;
        step();
        chk("cnt_under", 32'(outstanding), 0);
        chk("cnt_under_proto", 32'(proto_err), 1);
        do_reset();
        cmd_issue = 1'b1;
        cmd_done  = 1'b1;
        step();
        chk("cnt_both_zero", 32'(outstanding), 0);
        chk("cnt_both_proto", 32'(proto_err), 0);
        do_reset();
        req_valid = 1'b1;
        step();
        cmd_issue = 1'b1;
        step();
        cmd_issue = 1'b0;
        chk("blocked_issue_proto", 32'(proto_err), 1);
        chk("blocked_issue_cnt", 32'(outstanding), 1);

        // Reset while in GUARD.
        do_reset();
        req_valid = 1'b1;
        req_speed = 3'd6;
        repeat (3) step();
        chk("guard_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 1'b0;
        chk("guard_rst_block", 32'(cmd_block), 0);
        chk("guard_rst_ready", 32'(req_ready), 0);
        chk("guard_rst_speed", 32'(grant_speed), 0);

        // Request withdrawn mid-DRAIN.
        cmd_issue = 1'b1;
        step();
        cmd_issue = 1'b0;
        req_valid = 1'b1;
        step();
        step();
        chk("abort_in_drain", 32'(cmd_block), 1);
        req_valid = 1'b0;
        step();
        chk("abort_block", 32'(cmd_block), 0);
        for (int c = 0; c < 12; c++) begin
            chk("abort_noready", 32'(req_ready), 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
